// File: rtl/lab2rgb_pipe.sv
// CIE L*a*b* to clamped RGB: five-stage fixed-point pipeline under a single global stall,
// with a saturating count of delivered pixels that needed clamping.
module lab2rgb_pipe #(
   parameter int unsigned IN_W  = 18,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  CIEL,
   input  logic [IN_W-1:0]  CIEa,
   input  logic [IN_W-1:0]  CIEb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] R,
   output logic [OUT_W-1:0] G,
   output logic [OUT_W-1:0] B,
   output logic             out_sat,
   output logic [CNT_W-1:0] sat_count,
   input  logic             sat_clear
);

   localparam int unsigned AW = 48;
   typedef logic signed [AW-1:0] sw_t;

   localparam sw_t L_OFS = 48'sd26008;
   localparam sw_t K_Y   = 48'sd565;
   localparam sw_t K_A   = 48'sd131;
   localparam sw_t K_B   = 48'sd328;
   localparam sw_t F_MIN = 48'sd53;
   localparam sw_t W_X   = 48'sd242;
   localparam sw_t W_Y   = 48'sd255;
   localparam sw_t W_Z   = 48'sd278;
   localparam sw_t M_RX  = 48'sd830;
   localparam sw_t M_RY  = 48'sd394;
   localparam sw_t M_RZ  = 48'sd128;
   localparam sw_t M_GX  = 48'sd248;
   localparam sw_t M_GY  = 48'sd480;
   localparam sw_t M_GZ  = 48'sd11;
   localparam sw_t M_BX  = 48'sd14;
   localparam sw_t M_BY  = 48'sd52;
   localparam sw_t M_BZ  = 48'sd271;
   localparam sw_t C_MAX = sw_t'({OUT_W{1'b1}});

   // Lower bound then drop the 20 fractional bits (arithmetic shift = floor).
   function automatic sw_t floor_shift(input sw_t v);
      sw_t t;
      t = (v < F_MIN) ? F_MIN : v;
      return t >>> 20;
   endfunction

   // {clamped flag, channel value}
   function automatic logic [OUT_W:0] clamp(input sw_t v);
      logic [OUT_W:0] res;
      if (v[AW-1])
         res = {1'b1, {OUT_W{1'b0}}};
      else if (v > C_MAX)
         res = {1'b1, {OUT_W{1'b1}}};
      else
         res = {1'b0, v[OUT_W-1:0]};
      return res;
   endfunction

   logic advance;
   logic v1, v2, v3, v4;
   sw_t  s1_x, s1_y, s1_z;
   sw_t  s2_x, s2_y, s2_z;
   sw_t  s3_x, s3_y, s3_z;
   sw_t  s4_x, s4_y, s4_z;

   sw_t  l_ext, a_ext, b_ext;
   sw_t  fx_c, fy_c, fz_c;
   sw_t  rr_c, gg_c, bb_c;
   logic [OUT_W:0] rc_c, gc_c, bc_c;

   // One stall signal for the whole pipe: it moves whenever the output slot can drain.
   always_comb begin
      advance  = !out_valid || out_ready;
      in_ready = advance;
   end

   always_comb begin
      l_ext = sw_t'({{(AW-IN_W){1'b0}}, CIEL});
      a_ext = sw_t'({{(AW-IN_W){CIEa[IN_W-1]}}, CIEa});
      b_ext = sw_t'({{(AW-IN_W){CIEb[IN_W-1]}}, CIEb});
      fy_c  = (l_ext + L_OFS) * K_Y;
      fx_c  = a_ext * K_A + fy_c;
      fz_c  = fy_c - b_ext * K_B;
   end

   // XYZ to RGB matrix and per-channel clamp feeding the output register.
   always_comb begin
      rr_c = (M_RX * s4_x - M_RY * s4_y - M_RZ * s4_z) >>> 12;
      gg_c = (M_GY * s4_y + M_GZ * s4_z - M_GX * s4_x) >>> 12;
      bb_c = (M_BX * s4_x - M_BY * s4_y + M_BZ * s4_z) >>> 12;
      rc_c = clamp(rr_c);
      gc_c = clamp(gg_c);
      bc_c = clamp(bb_c);
   end

   // Datapath registers carry no reset; the valid chain qualifies them.
   always_ff @(posedge clk) begin
      if (advance) begin
         if (in_valid) begin
            s1_x <= fx_c;
            s1_y <= fy_c;
            s1_z <= fz_c;
         end
         if (v1) begin
            s2_x <= floor_shift(s1_x);
            s2_y <= floor_shift(s1_y);
            s2_z <= floor_shift(s1_z);
         end
         if (v2) begin
            s3_x <= s2_x * s2_x * s2_x;
            s3_y <= s2_y * s2_y * s2_y;
            s3_z <= s2_z * s2_z * s2_z;
         end
         if (v3) begin
            s4_x <= (s3_x * W_X) >>> 8;
            s4_y <= (s3_y * W_Y) >>> 8;
            s4_z <= (s3_z * W_Z) >>> 8;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         v4        <= 1'b0;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
         R         <= '0;
         G         <= '0;
         B         <= '0;
         sat_count <= '0;
      end else begin
         if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) begin
               R       <= rc_c[OUT_W-1:0];
               G       <= gc_c[OUT_W-1:0];
               B       <= bc_c[OUT_W-1:0];
               out_sat <= rc_c[OUT_W] | gc_c[OUT_W] | bc_c[OUT_W];
            end
         end
         // Clear wins over a coincident counted handshake.
         if (sat_clear)
            sat_count <= '0;
         else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}}))
            sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_lab2rgb_pipe.sv
// Directed and random checks of lab2rgb_pipe: latency, clamping, stalls, reset, counter.
module tb_lab2rgb_pipe;

   localparam int unsigned IN_W  = 18;
   localparam int unsigned OUT_W = 8;
   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      logic             sat;
      logic [OUT_W-1:0] r;
      logic [OUT_W-1:0] g;
      logic [OUT_W-1:0] b;
   } pix_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  ciel, ciea, cieb;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] r, g, b;
   logic             out_sat;
   logic [CNT_W-1:0] sat_count;
   logic             sat_clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lab2rgb_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .CIEL(ciel), .CIEa(ciea), .CIEb(cieb),
      .out_valid(out_valid), .out_ready(out_ready),
      .R(r), .G(g), .B(b), .out_sat(out_sat),
      .sat_count(sat_count), .sat_clear(sat_clear)
   );

   // Straight transcription of the colour formulas in 64-bit signed arithmetic.
   function automatic pix_t model(input logic [IN_W-1:0] cl, input logic [IN_W-1:0] ca,
                                  input logic [IN_W-1:0] cb);
      longint l, a, bv, fx, fy, fz, x, y, z;
      longint ch[3];
      pix_t   p;
      l  = longint'(cl);
      a  = longint'($signed(ca));
      bv = longint'($signed(cb));
      fy = (l + 26008) * 565;
      fx = a * 131 + fy;
      fz = fy - bv * 328;
      if (fx < 53) fx = 53;
      if (fy < 53) fy = 53;
      if (fz < 53) fz = 53;
      fx = fx >>> 20;
      fy = fy >>> 20;
      fz = fz >>> 20;
      x = (fx * fx * fx * 242) >>> 8;
      y = (fy * fy * fy * 255) >>> 8;
      z = (fz * fz * fz * 278) >>> 8;
      ch[0] = (830 * x - 394 * y - 128 * z) >>> 12;
      ch[1] = (-248 * x + 480 * y + 11 * z) >>> 12;
      ch[2] = (14 * x - 52 * y + 271 * z) >>> 12;
      p.sat = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (ch[i] < 0) begin
            ch[i] = 0;
            p.sat = 1'b1;
         end else if (ch[i] > 255) begin
            ch[i] = 255;
            p.sat = 1'b1;
         end
      end
      p.r = OUT_W'(ch[0]);
      p.g = OUT_W'(ch[1]);
      p.b = OUT_W'(ch[2]);
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_neutral();
      do_reset();
      ciel = '0; ciea = '0; cieb = '0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL neutral_early_valid after edge %0d got %b want 0", k, out_valid);
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL neutral_latency out_valid got %b want 1", out_valid);
      end
      checks++;
      if ({out_sat, r, g, b} !== {1'b0, 8'd169, 8'd171, 8'd171}) begin
         errors++;
         $display("FAIL neutral_rgb got sat=%b R=%0d G=%0d B=%0d want sat=0 R=169 G=171 B=171",
                  out_sat, r, g, b);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sat_count !== '0) begin
         errors++;
         $display("FAIL neutral_drain got valid=%b count=%0d want 0 0", out_valid, sat_count);
      end
   endtask

   // -200000 does not fit 18 bits; the most negative a drives fX below the floor just the same.
   task automatic test_neg_a();
      ciel = '0; ciea = 18'h20000; cieb = '0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if ({out_valid, out_sat, r, g, b} !== {1'b1, 1'b1, 8'd0, 8'd255, 8'd162}) begin
         errors++;
         $display("FAIL neg_a_rgb got v=%b sat=%b R=%0d G=%0d B=%0d want v=1 sat=1 R=0 G=255 B=162",
                  out_valid, out_sat, r, g, b);
      end
      checks++;
      if (sat_count !== 4'd0) begin
         errors++;
         $display("FAIL neg_a_count_before got %0d want 0", sat_count);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (sat_count !== 4'd1) begin
         errors++;
         $display("FAIL neg_a_count_after got %0d want 1", sat_count);
      end
   endtask

   task automatic test_reset();
      ciel = '0; ciea = '0; cieb = '0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k < 7; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_prestall got valid=%b in_ready=%b want 1 0", out_valid, in_ready);
      end
      reset = 1'b1; sat_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; sat_clear = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_sat, r, g, b, sat_count} !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%b sat=%b R=%0d G=%0d B=%0d cnt=%0d want all 0",
                  out_valid, out_sat, r, g, b, sat_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      int   vl[8] = '{0, 262143, 100000, 50000, 200000, 0, 150000, 30000};
      int   va[8] = '{0, 0, -131072, 20000, -40000, 60000, 5000, -10000};
      int   vb[8] = '{0, 0, 0, -30000, 50000, 10000, -131072, 131071};
      pix_t expq[$];
      pix_t hold_v, e;
      logic held = 1'b0;
      int   sent = 0;
      int   got = 0;
      do_reset();
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 8) begin
            in_valid = 1'b1;
            ciel = IN_W'(vl[sent]); ciea = IN_W'(va[sent]); cieb = IN_W'(vb[sent]);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready,
                     !(out_valid && !out_ready));
         end
         if (held) begin
            checks++;
            if ({out_valid, out_sat, r, g, b} !== {1'b1, hold_v}) begin
               errors++;
               $display("FAIL bp_hold cyc %0d got v=%b %h want v=1 %h", cyc, out_valid,
                        {out_sat, r, g, b}, hold_v);
            end
         end
         if (out_valid) begin
            if (!held) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL bp_spurious cyc %0d got %h want no output", cyc, {out_sat, r, g, b});
               end else if ({out_sat, r, g, b} !== expq[0]) begin
                  errors++;
                  $display("FAIL bp_data #%0d got %h want %h", got, {out_sat, r, g, b}, expq[0]);
               end
            end
            held   = !out_ready;
            hold_v = {out_sat, r, g, b};
            if (out_ready && expq.size() != 0) begin
               e = expq.pop_front();
               got++;
            end
         end else begin
            held = 1'b0;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(ciel, ciea, cieb));
            sent++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 8 || sent != 8) begin
         errors++;
         $display("FAIL bp_count got sent=%0d recv=%0d want 8 8", sent, got);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ciel = IN_W'(1000 * i); ciea = '0; cieb = '0; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_in_ready got %b want 1", in_ready);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flushed cyc %0d got out_valid=%b want 0", k, out_valid);
         end
         @(posedge clk);
         @(negedge clk);
      end
      ciel = '0; ciea = '0; cieb = '0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early after edge %0d got %b want 0", k, out_valid);
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if ({out_valid, out_sat, r, g, b} !== {1'b1, 1'b0, 8'd169, 8'd171, 8'd171}) begin
         errors++;
         $display("FAIL midreset_pixel got v=%b sat=%b R=%0d G=%0d B=%0d want 1 0 169 171 171",
                  out_valid, out_sat, r, g, b);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_counter();
      logic found = 1'b0;
      do_reset();
      ciel = 18'd262143; ciea = '0; cieb = '0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (sat_count !== {CNT_W{1'b1}}) begin
         errors++;
         $display("FAIL cnt_saturate got %0d want %0d", sat_count, {CNT_W{1'b1}});
      end
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (out_valid) found = 1'b1;
         else begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      checks++;
      if (!found || {out_sat, r, g, b} !== {1'b1, 8'd255, 8'd255, 8'd255}) begin
         errors++;
         $display("FAIL cnt_sat_pixel got found=%b sat=%b R=%0d G=%0d B=%0d want 1 1 255 255 255",
                  found, out_sat, r, g, b);
      end
      checks++;
      if (sat_count !== {CNT_W{1'b1}}) begin
         errors++;
         $display("FAIL cnt_hold_max got %0d want %0d", sat_count, {CNT_W{1'b1}});
      end
      sat_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sat_clear = 1'b0;
      checks++;
      if (sat_count !== '0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL cnt_clear_priority got cnt=%0d valid=%b want 0 0", sat_count, out_valid);
      end
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (sat_count !== 4'd1) begin
         errors++;
         $display("FAIL cnt_after_clear got %0d want 1", sat_count);
      end
   endtask

   task automatic test_random();
      pix_t expq[$];
      pix_t e;
      logic [IN_W-1:0] rl, ra, rb;
      int sent = 0;
      int got = 0;
      do_reset();
      for (int cyc = 0; cyc < 10100 && got < 10000; cyc++) begin
         if (out_valid) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious cyc %0d got %h want no output", cyc, {out_sat, r, g, b});
            end else begin
               e = expq.pop_front();
               got++;
               if ({out_sat, r, g, b} !== e) begin
                  errors++;
                  $display("FAIL rand_data #%0d got %h want %h", got - 1, {out_sat, r, g, b}, e);
               end
            end
         end
         if (sent < 10000) begin
            rl = IN_W'($urandom); ra = IN_W'($urandom); rb = IN_W'($urandom);
            ciel = rl; ciea = ra; cieb = rb; in_valid = 1'b1;
            expq.push_back(model(rl, ra, rb));
            sent++;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (got != 10000) begin
         errors++;
         $display("FAIL rand_count got %0d want 10000", got);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
      ciel = '0; ciea = '0; cieb = '0;
      test_neutral();
      test_neg_a();
      test_reset();
      test_back_to_back();
      test_reset_midstream();
      test_counter();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
